// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Default VGA 640x480@60 timing constants, derived totals and
//               the 10-bit position type shared by the video_timing slice.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam int c_pos_w    = 10;

    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;

    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;

    localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    typedef logic [c_pos_w-1:0] pos_t;

    // Half-open window test [lo, hi).
    function automatic logic in_window(input int value, input int lo, input int hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage : video_pkg
`default_nettype wire

// File: rtl/video_timing_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_if
// Description : Timing-generator output bundle plus the line-interrupt
//               request input. master = timing generator, slave = consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_if;
    import video_pkg::*;

    pos_t irq_line;
    pos_t hpos;
    pos_t vpos;
    logic active;
    logic hsync_n;
    logic vsync_n;
    logic frame_start;
    logic line_irq;

    modport master (
        input  irq_line,
        output hpos,
        output vpos,
        output active,
        output hsync_n,
        output vsync_n,
        output frame_start,
        output line_irq
    );

    modport slave (
        output irq_line,
        input  hpos,
        input  vpos,
        input  active,
        input  hsync_n,
        input  vsync_n,
        input  frame_start,
        input  line_irq
    );

endinterface : video_timing_if
`default_nettype wire

// File: rtl/video_timing_sync_window.sv
`default_nettype none
// ============================================================================
// Module      : sync_window
// Description : Registered flag that is high one cycle after the count lies
//               in the half-open window [LO, HI).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_window
    import video_pkg::*;
#(
    parameter int LO = 0,
    parameter int HI = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire pos_t i_count,
    output logic      o_in_window
);

    logic r_in_window;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_window <= 1'b0;
        end else begin
            r_in_window <= in_window(int'(i_count), LO, HI);
        end
    end

    assign o_in_window = r_in_window;

endmodule : sync_window
`default_nettype wire

// File: rtl/video_timing.sv
`default_nettype none
// ============================================================================
// Module      : video_timing
// Description : Raster timing generator with one-cycle registered outputs.
//               Optional macro VIDEO_TIMING_LOCK_GATE_EN adds a pll_locked
//               port that holds the generator in reset while low.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp
) (
    input  wire logic      clk,
    input  wire logic      reset,
`ifdef VIDEO_TIMING_LOCK_GATE_EN
    input  wire logic      pll_locked,
`endif
    video_timing_if.master bus
);

    localparam int   c_h_tot  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   c_v_tot  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam pos_t c_h_last = pos_t'(c_h_tot - 1);
    localparam pos_t c_v_last = pos_t'(c_v_tot - 1);

    generate
        if ((c_h_tot > 1024) || (c_v_tot > 1024)) begin : g_bad_totals
            $error("video_timing: H/V totals must not exceed 1024");
        end
    endgenerate

    // Loss of PLL lock is treated exactly like reset.
    logic w_hold;
`ifdef VIDEO_TIMING_LOCK_GATE_EN
    assign w_hold = reset | ~pll_locked;
`else
    assign w_hold = reset;
`endif

    pos_t r_h;
    pos_t r_v;
    logic w_h_wrap;
    logic w_v_wrap;

    assign w_h_wrap = (r_h == c_h_last);
    assign w_v_wrap = (r_v == c_v_last);

    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_wrap) begin
            r_h <= '0;
            r_v <= w_v_wrap ? '0 : r_v + pos_t'(1);
        end else begin
            r_h <= r_h + pos_t'(1);
        end
    end

    pos_t r_hpos;
    pos_t r_vpos;
    logic r_frame_start;
    logic r_line_irq;

    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_frame_start <= 1'b0;
            r_line_irq    <= 1'b0;
        end else begin
            r_hpos        <= r_h;
            r_vpos        <= r_v;
            r_frame_start <= (r_h == '0) && (r_v == '0);
            // v never reaches irq_line >= total, so out-of-range never fires.
            r_line_irq    <= (r_h == '0) && (r_v == bus.irq_line);
        end
    end

    logic w_h_act;
    logic w_v_act;
    logic w_h_sync;
    logic w_v_sync;

    sync_window #(.LO(0), .HI(H_ACTIVE)) u_h_active (
        .clk         (clk),
        .rst         (w_hold),
        .i_count     (r_h),
        .o_in_window (w_h_act)
    );

    sync_window #(.LO(0), .HI(V_ACTIVE)) u_v_active (
        .clk         (clk),
        .rst         (w_hold),
        .i_count     (r_v),
        .o_in_window (w_v_act)
    );

    sync_window #(.LO(H_ACTIVE + H_FP), .HI(H_ACTIVE + H_FP + H_SYNC)) u_hsync (
        .clk         (clk),
        .rst         (w_hold),
        .i_count     (r_h),
        .o_in_window (w_h_sync)
    );

    // v only changes on the h wrap, so vsync edges land at h = 0.
    sync_window #(.LO(V_ACTIVE + V_FP), .HI(V_ACTIVE + V_FP + V_SYNC)) u_vsync (
        .clk         (clk),
        .rst         (w_hold),
        .i_count     (r_v),
        .o_in_window (w_v_sync)
    );

    assign bus.hpos        = r_hpos;
    assign bus.vpos        = r_vpos;
    assign bus.active      = w_h_act & w_v_act;
    assign bus.hsync_n     = ~w_h_sync;
    assign bus.vsync_n     = ~w_v_sync;
    assign bus.frame_start = r_frame_start;
    assign bus.line_irq    = r_line_irq;

endmodule : video_timing
`default_nettype wire

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, 25 MHz pixel clock from PLL core output
- reset, in, 1, synchronous, active-high
- pll_locked, in, 1, PLL lock status; present only with VIDEO_TIMING_LOCK_GATE_EN
- irq_line, in, 10, line number that raises line_irq
- hpos, out, 10, horizontal position of the current output pixel
- vpos, out, 10, vertical position of the current output pixel
- active, out, 1, pixel is inside the visible area
- hsync_n, out, 1, horizontal sync, active-low
- vsync_n, out, 1, vertical sync, active-low
- frame_start, out, 1, one-cycle pulse at position (0,0)
- line_irq, out, 1, one-cycle pulse at position (0,irq_line)

Function
REQ-003 Counters: internal h counter 0..H_TOTAL-1 and v counter 0..V_TOTAL-1, where H_TOTAL = sum of the H_* parameters (800) and V_TOTAL = sum of the V_* parameters (525).
REQ-004 h counter increments every enabled cycle.
REQ-005 h wraps H_TOTAL-1 -> 0; v increments on that same cycle.
REQ-006 v wraps V_TOTAL-1 -> 0 on the cycle where h wraps and v = V_TOTAL-1.
REQ-007 All outputs are registered with a latency of exactly one cycle: outputs in cycle n reflect the counter value of cycle n-1.
REQ-008 active = (h < H_ACTIVE) && (v < V_ACTIVE).
REQ-009 hsync_n = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
REQ-010 vsync_n = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults); vsync timing is line-granular and changes at h = 0.
REQ-011 hpos = h and vpos = v, zero-extended to 10 bits.
REQ-012 frame_start = 1 iff (h,v) = (0,0).
REQ-013 line_irq = 1 iff h = 0 and v = irq_line.
REQ-014 irq_line is sampled each cycle; irq_line >= V_TOTAL never fires.
REQ-015 If irq_line changes mid-line, the new value applies from the next h = 0.
REQ-016 frame_start and line_irq assert in the same cycle when irq_line = 0.
REQ-017 Totals exceeding 1024 are a parameter error; flag with an elaboration-time assertion.

Reset
REQ-018 While reset = 1: h = v = 0; hpos = vpos = 0; active = 0; hsync_n = vsync_n = 1; frame_start = line_irq = 0.
REQ-019 First cycle after reset release: outputs show (0,0), active = 1, frame_start = 1.
REQ-020 Reset asserted mid-frame takes effect on the next clock edge with no partial-line completion.

Configuration
REQ-021 Macro VIDEO_TIMING_LOCK_GATE_EN defined: the pll_locked port exists.
REQ-022 With the macro, pll_locked = 0 behaves identically to reset = 1: counters are held at (0,0) and outputs are held at their reset values.
REQ-023 With the macro, a rising edge of pll_locked behaves as reset release per REQ-019.
REQ-024 Macro undefined: the port is absent and counting is governed by reset only.

Structure
REQ-025 Shared package video_pkg holds the default timing constants (640/16/96/48, 480/10/2/33), derived H_TOTAL/V_TOTAL, and a position typedef (10-bit unsigned).
REQ-026 Sub-module sync_window: parameterised compare, in = count, out = registered in-window flag. It is instantiated for hsync, vsync, h-active and v-active.

Verification
REQ-027 Release reset, run 800*525 cycles -> exactly one frame_start; second frame_start exactly 420000 cycles after the first.
REQ-028 Count per line at defaults -> 640 active cycles, hsync_n low for 96 cycles starting at hpos = 656.
REQ-029 Count per frame -> vsync_n low for exactly 1600 cycles (2 lines) starting at (0,490).
REQ-030 irq_line = 100 -> line_irq once per frame at (0,100); irq_line = 600 -> never; irq_line = 0 -> pulse coincident with frame_start.
REQ-031 Assert reset at (300,200) for 3 cycles -> outputs at reset values during reset, (0,0) with frame_start on the first cycle after release.
REQ-032 With VIDEO_TIMING_LOCK_GATE_EN: drop pll_locked mid-frame for 10 cycles -> behaviour matches REQ-031; without the macro the bench compiles with no pll_locked port.
